// File: rtl/div_even_ctrl_pkg.sv
// Shared types and helpers for the even clock divider: FSM states,
// divide-factor field width and the divide-factor legality rule.
package div_even_ctrl_pkg;

   typedef enum logic [1:0] {
      STOP   = 2'd0,
      RUN    = 2'd1,
      SWITCH = 2'd2,
      HALT   = 2'd3
   } state_t;

   // Width of every divide-factor field for a given largest factor.
   function automatic int div_width(input int max_div);
      return $clog2(max_div) + 1;
   endfunction

   function automatic logic div_is_legal(input int unsigned div, input int unsigned max_div);
      return (div[0] == 1'b0) && (div >= 32'd2) && (div <= max_div);
   endfunction

endpackage

// File: rtl/div_even_ctrl_if.sv
// Configuration handshake and divided-clock status bundle for div_even_ctrl.
interface div_even_ctrl_if
   import div_even_ctrl_pkg::*;
#(
   parameter int DW = div_width(16)
);
   logic          enable;
   logic          cfg_valid;
   logic [DW-1:0] cfg_div;
   logic          cfg_ready;
   logic          cfg_err;
   logic          clk_out;
   logic [DW-1:0] cur_div;
   logic          busy;

   modport master (
      output enable, cfg_valid, cfg_div,
      input  cfg_ready, cfg_err, clk_out, cur_div, busy
   );

   modport slave (
      input  enable, cfg_valid, cfg_div,
      output cfg_ready, cfg_err, clk_out, cur_div, busy
   );
endinterface

// File: rtl/div_even_core.sv
// Half-period counter and registered clk_out toggle flop. Flags the cycle in
// which the next toggle takes clk_out from high to low.
module div_even_core
   import div_even_ctrl_pkg::*;
#(
   parameter int DW = div_width(16)
) (
   input  logic          clk_in,
   input  logic          rst,
   input  logic [DW-1:0] half_period,
   input  logic          run,
   input  logic          load_clr,
   output logic          clk_out,
   output logic          fall_evt
);
   localparam logic [DW-1:0] ONE = DW'(1);

   logic [DW-1:0] count_reg;
   logic          clk_out_reg;
   logic          terminal;

   assign terminal = (count_reg == (half_period - ONE));
   assign fall_evt = run && terminal && clk_out_reg;
   assign clk_out  = clk_out_reg;

   // load_clr only ever coincides with a falling toggle, so it lands in the
   // same low/zero state the toggle would have produced.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         count_reg   <= '0;
         clk_out_reg <= 1'b0;
      end else if (!run || load_clr) begin
         count_reg   <= '0;
         clk_out_reg <= 1'b0;
      end else if (terminal) begin
         count_reg   <= '0;
         clk_out_reg <= ~clk_out_reg;
      end else begin
         count_reg   <= count_reg + ONE;
      end
   end

endmodule

// File: rtl/div_even_ctrl.sv
// Even-factor clock divider controller: configuration handshake, glitch-free
// factor switching and clean stop, all aligned to falling edges of clk_out.
module div_even_ctrl
   import div_even_ctrl_pkg::*;
#(
   parameter int MAX_DIV   = 16,
   parameter int RESET_DIV = 2
) (
   input  logic            clk_in,
   input  logic            rst,
   div_even_ctrl_if.slave  bus
);
   localparam int            DW        = div_width(MAX_DIV);
   localparam logic [DW-1:0] RESET_VAL = DW'(RESET_DIV);

   state_t        state_reg, state_next;
   logic [DW-1:0] cur_div_reg, cur_div_next;
   logic [DW-1:0] pending_reg, pending_next;
   logic          cfg_err_reg, cfg_err_next;

   logic          cfg_ready;
   logic          accept;
   logic          legal;
   logic          run;
   logic          load_clr;
   logic          fall_evt;
   logic          clk_div;
   logic [DW-1:0] half_period;

   assign cfg_ready   = (state_reg == STOP) || (state_reg == RUN);
   assign accept      = bus.cfg_valid && cfg_ready;
   assign legal       = div_is_legal(32'(bus.cfg_div), MAX_DIV);
   assign run         = (state_reg != STOP);
   assign half_period = cur_div_reg >> 1;

   div_even_core #(
      .DW (DW)
   ) u_core (
      .clk_in      (clk_in),
      .rst         (rst),
      .half_period (half_period),
      .run         (run),
      .load_clr    (load_clr),
      .clk_out     (clk_div),
      .fall_evt    (fall_evt)
   );

   always_comb begin
      state_next   = state_reg;
      cur_div_next = cur_div_reg;
      pending_next = pending_reg;
      cfg_err_next = 1'b0;
      load_clr     = 1'b0;

      case (state_reg)
         STOP: begin
            if (accept) begin
               if (legal) cur_div_next = bus.cfg_div;
               else       cfg_err_next = 1'b1;
            end
            if (bus.enable) state_next = RUN;
         end

         RUN: begin
            if (accept && legal) begin
               pending_next = bus.cfg_div;
               state_next   = SWITCH;
            end else begin
               if (accept)       cfg_err_next = 1'b1;
               if (!bus.enable)  state_next   = HALT;
            end
         end

         // New factor takes over exactly at the falling edge so the next
         // low phase is the first one timed by it.
         SWITCH: begin
            if (fall_evt) begin
               cur_div_next = pending_reg;
               load_clr     = 1'b1;
               state_next   = bus.enable ? RUN : STOP;
            end
         end

         HALT: begin
            if (bus.enable)    state_next = RUN;
            else if (fall_evt) state_next = STOP;
         end

         default: state_next = STOP;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state_reg   <= STOP;
         cur_div_reg <= RESET_VAL;
         pending_reg <= RESET_VAL;
         cfg_err_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cur_div_reg <= cur_div_next;
         pending_reg <= pending_next;
         cfg_err_reg <= cfg_err_next;
      end
   end

   assign bus.cfg_ready = cfg_ready;
   assign bus.cfg_err   = cfg_err_reg;
   assign bus.clk_out   = clk_div;
   assign bus.cur_div   = cur_div_reg;
   assign bus.busy      = run;

endmodule
